// File: rtl/spi_slave_duplex_if.sv
// spi_slave_duplex_if
//   Groups the SPI pin signals and the core-side TX/RX handshake of
//   spi_slave_duplex into one bundle.
//   Pins  : SCLK, MOSI, SS (master -> slave), MISO, MISO_oe (slave -> master)
//   Config: mode = {CPOL, CPHA}
//   TX    : tx_data, tx_valid (core -> slave), tx_ready (slave -> core)
//   RX    : rx_data, rx_valid (slave -> core)
//   Status: tx_underrun, frame_err, busy (slave -> core)
//   Modport slave is used by the design, master by whatever drives it.
interface spi_slave_duplex_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  SCLK;
    logic                  MOSI;
    logic                  SS;
    logic                  MISO;
    logic                  MISO_oe;
    logic [1:0]            mode;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;
    logic                  frame_err;
    logic                  busy;

    modport slave (
        input  SCLK, MOSI, SS, mode, tx_data, tx_valid,
        output MISO, MISO_oe, tx_ready, rx_data, rx_valid,
               tx_underrun, frame_err, busy
    );

    modport master (
        output SCLK, MOSI, SS, mode, tx_data, tx_valid,
        input  MISO, MISO_oe, tx_ready, rx_data, rx_valid,
               tx_underrun, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_duplex.sv
// spi_slave_duplex
//   Full-duplex SPI slave supporting all four SPI modes. SCLK, MOSI and SS
//   are synchronised to clock; received words appear on rx_data with a
//   one-cycle rx_valid pulse while a one-entry TX holding register feeds
//   the MISO shifter. Words repeat back-to-back while SS stays low.
//   Ports:
//     clock : system clock, rising edge
//     reset : synchronous, active-high
//     bus   : spi_slave_duplex_if.slave (pins, mode, TX/RX handshake, status)
module spi_slave_duplex #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    spi_slave_duplex_if.slave   bus
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [SYNC_STAGES-1:0]  r_sclk_sync;
    logic [SYNC_STAGES-1:0]  r_mosi_sync;
    logic [SYNC_STAGES-1:0]  r_ss_sync;
    logic                    r_sclk_d;
    logic                    r_ss_d;

    logic [1:0]              r_mode;
    logic [CW-1:0]           r_bit_cnt;
    logic                    r_word_done;
    logic [DATA_WIDTH-1:0]   r_tx_shift;
    logic [DATA_WIDTH-2:0]   r_rx_shift;
    logic [DATA_WIDTH-1:0]   r_txbuf;
    logic                    r_txbuf_full;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic                    r_rx_valid;
    logic                    r_tx_underrun;
    logic                    r_frame_err;

    logic                    w_sclk_s;
    logic                    w_mosi_s;
    logic                    w_ss_s;
    logic                    w_sclk_rise;
    logic                    w_sclk_fall;
    logic                    w_ss_fall;
    logic                    w_ss_rise;
    logic                    w_lead;
    logic                    w_trail;
    logic                    w_sample;
    logic                    w_shift;
    logic                    w_start;
    logic                    w_stop;
    logic                    w_sample_en;
    logic                    w_shift_en;
    logic                    w_last_bit;
    logic                    w_reload;
    logic [DATA_WIDTH-1:0]   w_rx_next;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_ss_fall   = ~w_ss_s & r_ss_d;
    assign w_ss_rise   = w_ss_s & ~r_ss_d;

    // Edge roles come from the mode latched at SS fall.
    assign w_lead   = r_mode[1] ? w_sclk_fall : w_sclk_rise;
    assign w_trail  = r_mode[1] ? w_sclk_rise : w_sclk_fall;
    assign w_sample = r_mode[0] ? w_trail : w_lead;
    assign w_shift  = r_mode[0] ? w_lead  : w_trail;

    assign w_last_bit = (r_bit_cnt == CW'(DATA_WIDTH - 1));
    assign w_reload   = w_start | (w_shift_en & (r_bit_cnt == '0) & r_word_done);
    assign w_rx_next  = {r_rx_shift, w_mosi_s};

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // SS rise is checked first so a coincident sample edge is dropped.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_stop       = 1'b0;
        w_sample_en  = 1'b0;
        w_shift_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_state_next = ACTIVE;
                    w_start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_ss_rise) begin
                    w_state_next = IDLE;
                    w_stop       = 1'b1;
                end else begin
                    w_sample_en = w_sample;
                    w_shift_en  = w_shift;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sclk_sync   <= '0;
            r_mosi_sync   <= '0;
            r_ss_sync     <= '1;
            r_sclk_d      <= 1'b0;
            r_ss_d        <= 1'b1;
            r_mode        <= '0;
            r_bit_cnt     <= '0;
            r_word_done   <= 1'b0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_txbuf       <= '0;
            r_txbuf_full  <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
            r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
            r_ss_sync     <= {r_ss_sync[SYNC_STAGES-2:0], bus.SS};
            r_sclk_d      <= w_sclk_s;
            r_ss_d        <= w_ss_s;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;

            // Capture is only possible while empty, so a load in the same
            // cycle finds the slot empty (underrun) and the new word stays
            // buffered for the next load.
            if (bus.tx_valid && !r_txbuf_full) begin
                r_txbuf      <= bus.tx_data;
                r_txbuf_full <= 1'b1;
            end else if (w_reload) begin
                r_txbuf_full <= 1'b0;
            end

            if (w_reload) begin
                r_tx_shift    <= r_txbuf_full ? r_txbuf : '0;
                r_tx_underrun <= ~r_txbuf_full;
            end else if (w_shift_en && (r_bit_cnt != '0)) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            if (w_start) begin
                r_mode      <= bus.mode;
                r_bit_cnt   <= '0;
                r_word_done <= 1'b0;
            end else if (w_sample_en) begin
                r_rx_shift <= w_rx_next[DATA_WIDTH-2:0];
                if (w_last_bit) begin
                    r_rx_data   <= w_rx_next;
                    r_rx_valid  <= 1'b1;
                    r_bit_cnt   <= '0;
                    r_word_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end else if (w_reload) begin
                r_word_done <= 1'b0;
            end

            if (w_stop && (r_bit_cnt != '0)) r_frame_err <= 1'b1;
        end
    end

    assign bus.MISO        = (r_state == ACTIVE) & r_tx_shift[DATA_WIDTH-1];
    assign bus.MISO_oe     = ~w_ss_s;
    assign bus.tx_ready    = ~r_txbuf_full;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.tx_underrun = r_tx_underrun;
    assign bus.frame_err   = r_frame_err;
    assign bus.busy        = (r_state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_duplex.sv
// tb_spi_slave_duplex
//   Directed bench for spi_slave_duplex: a bit-banged SPI master drives the
//   pins, a table of single-word frames covers the four modes and the
//   underrun case, and hand-written sequences cover multi-word frames,
//   partial-word abort and reset in mid-word.
module tb_spi_slave_duplex;

    localparam int DW = 8;
    localparam int H  = 8;   // SCLK half period and SS setup, in clocks

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    spi_slave_duplex_if #(.DATA_WIDTH(DW)) bus ();

    spi_slave_duplex #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int unsigned n_rxv  = 0;
    int unsigned n_und  = 0;
    int unsigned n_ferr = 0;
    int unsigned n_pass = 0;
    int unsigned n_tot  = 0;

    always @(negedge clock) begin
        if (bus.rx_valid    === 1'b1) n_rxv++;
        if (bus.tx_underrun === 1'b1) n_und++;
        if (bus.frame_err   === 1'b1) n_ferr++;
    end

    typedef struct {
        logic [1:0] mode;
        logic       has_tx;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_und;
    } vec_t;

    vec_t vecs[6];

    task automatic clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic push_tx(input logic [7:0] v);
        int k = 0;
        while (bus.tx_ready !== 1'b1 && k < 200) begin
            clk(1);
            k++;
        end
        chk("tx_ready_wait", {31'd0, bus.tx_ready}, 32'd1);
        bus.tx_data  = v;
        bus.tx_valid = 1'b1;
        clk(1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic start_frame(input logic [1:0] m);
        bus.mode = m;
        bus.SCLK = m[1];
        clk(H);
        bus.SS = 1'b0;
        clk(H);
    endtask

    task automatic end_frame();
        clk(H);
        bus.SS = 1'b1;
        clk(H);
    endtask

    task automatic xfer_word(input logic [1:0] m, input logic [7:0] tx,
                             input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!m[0]) begin
                bus.MOSI = tx[7-i];
                clk(H);
                rx = {rx[6:0], bus.MISO};
                bus.SCLK = ~m[1];
                clk(H);
                bus.SCLK = m[1];
            end else begin
                bus.SCLK = ~m[1];
                clk(H/2);
                bus.MOSI = tx[7-i];
                clk(H/2);
                rx = {rx[6:0], bus.MISO};
                bus.SCLK = m[1];
                clk(H);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_MISO"},        {31'd0, bus.MISO},        32'd0);
        chk({tag, "_MISO_oe"},     {31'd0, bus.MISO_oe},     32'd0);
        chk({tag, "_tx_ready"},    {31'd0, bus.tx_ready},    32'd1);
        chk({tag, "_rx_data"},     {24'd0, bus.rx_data},     32'd0);
        chk({tag, "_rx_valid"},    {31'd0, bus.rx_valid},    32'd0);
        chk({tag, "_tx_underrun"}, {31'd0, bus.tx_underrun}, 32'd0);
        chk({tag, "_frame_err"},   {31'd0, bus.frame_err},   32'd0);
        chk({tag, "_busy"},        {31'd0, bus.busy},        32'd0);
    endtask

    initial begin
        logic [7:0]  got;
        logic [7:0]  got2;
        int unsigned b_rxv, b_und, b_ferr;

        vecs[0] = '{2'd0, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 0};
        vecs[1] = '{2'd1, 1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81, 0};
        vecs[2] = '{2'd2, 1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81, 0};
        vecs[3] = '{2'd3, 1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81, 0};
        vecs[4] = '{2'd0, 1'b1, 8'h5A, 8'hC6, 8'hC6, 8'h5A, 0};
        vecs[5] = '{2'd1, 1'b0, 8'h00, 8'h99, 8'h99, 8'h00, 1};

        reset        = 1'b1;
        bus.SCLK     = 1'b0;
        bus.MOSI     = 1'b0;
        bus.SS       = 1'b1;
        bus.mode     = 2'd0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        clk(4);
        chk_reset_outputs("rst");
        reset = 1'b0;
        clk(H);

        for (int v = 0; v < 6; v++) begin
            b_rxv = n_rxv; b_und = n_und; b_ferr = n_ferr;
            if (vecs[v].has_tx) push_tx(vecs[v].tx);
            start_frame(vecs[v].mode);
            chk("busy_active", {31'd0, bus.busy},    32'd1);
            chk("oe_active",   {31'd0, bus.MISO_oe}, 32'd1);
            // CPHA=0 reloads on the trailing edge after the last bit, so a
            // filler word keeps that reload from counting as an underrun.
            if (vecs[v].has_tx && !vecs[v].mode[0]) push_tx(8'h00);
            xfer_word(vecs[v].mode, vecs[v].mosi, 8, got);
            end_frame();
            chk("vec_rx_data",  {24'd0, bus.rx_data}, {24'd0, vecs[v].exp_rx});
            chk("vec_miso",     {24'd0, got},         {24'd0, vecs[v].exp_miso});
            chk("vec_rx_valid", n_rxv - b_rxv,        32'd1);
            chk("vec_underrun", n_und - b_und,        vecs[v].exp_und);
            chk("vec_frame_err", n_ferr - b_ferr,     32'd0);
            chk("vec_busy_idle", {31'd0, bus.busy},   32'd0);
        end

        // Two words in one frame, second word supplied once tx_ready rises.
        b_rxv = n_rxv; b_und = n_und; b_ferr = n_ferr;
        push_tx(8'h12);
        start_frame(2'd0);
        push_tx(8'h34);
        xfer_word(2'd0, 8'hF0, 8, got);
        chk("w2_rx_first", {24'd0, bus.rx_data}, 32'h0F0);
        push_tx(8'h00);
        xfer_word(2'd0, 8'h0F, 8, got2);
        end_frame();
        chk("w2_rx_second", {24'd0, bus.rx_data}, 32'h00F);
        chk("w2_miso_first",  {24'd0, got},  32'h012);
        chk("w2_miso_second", {24'd0, got2}, 32'h034);
        chk("w2_rx_valid", n_rxv - b_rxv,   32'd2);
        chk("w2_underrun", n_und - b_und,   32'd0);
        chk("w2_frame_err", n_ferr - b_ferr, 32'd0);

        // Partial word: SS released after 5 bits.
        b_rxv = n_rxv; b_ferr = n_ferr;
        start_frame(2'd0);
        xfer_word(2'd0, 8'hAA, 5, got);
        end_frame();
        chk("ferr_pulse",    n_ferr - b_ferr,     32'd1);
        chk("ferr_no_valid", n_rxv - b_rxv,       32'd0);
        chk("ferr_rx_held",  {24'd0, bus.rx_data}, 32'h00F);
        b_rxv = n_rxv; b_ferr = n_ferr;
        start_frame(2'd0);
        xfer_word(2'd0, 8'h55, 8, got);
        end_frame();
        chk("after_ferr_rx",    {24'd0, bus.rx_data}, 32'h055);
        chk("after_ferr_valid", n_rxv - b_rxv,        32'd1);
        chk("after_ferr_ferr",  n_ferr - b_ferr,      32'd0);

        // Reset in mid-word aborts silently.
        b_ferr = n_ferr;
        start_frame(2'd0);
        xfer_word(2'd0, 8'hFF, 3, got);
        reset    = 1'b1;
        bus.SS   = 1'b1;
        bus.SCLK = 1'b0;
        clk(4);
        chk_reset_outputs("midrst");
        reset = 1'b0;
        clk(H);
        chk("midrst_no_ferr", n_ferr - b_ferr,      32'd0);
        chk("midrst_busy",    {31'd0, bus.busy},    32'd0);
        chk("midrst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        b_rxv = n_rxv;
        start_frame(2'd0);
        xfer_word(2'd0, 8'hC3, 8, got);
        end_frame();
        chk("post_rst_rx",    {24'd0, bus.rx_data}, 32'h0C3);
        chk("post_rst_valid", n_rxv - b_rxv,        32'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/spi_slave_duplex.md
# spi_slave_duplex

Parametrised full-duplex SPI slave with all four SPI modes, internal SCLK/MOSI/SS synchronisation, and multi-word frames. It replaces the receive-only slave path: it receives MOSI into `rx_data` and shifts a buffered `tx_data` word out on MISO in the same frame. It sits between the external SPI pins and the register/LED logic, on the single system `clock`. Valid/ready handshakes on the core side.

## Interface
- `DATA_WIDTH`, 8: bits per word, ≥ 2, MSB first.
- `SYNC_STAGES`, 2: synchroniser flops on SCLK, MOSI and SS, ≥ 2.
- `clock` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `SCLK` in 1: SPI clock from master, asynchronous.
- `MOSI` in 1: master-out data, asynchronous.
- `SS` in 1: slave select, active-low, asynchronous.
- `MISO` out 1: slave-out data; 0 when not selected.
- `MISO_oe` out 1: pad output enable; 1 while synchronised SS is low.
- `mode` in 2: {CPOL, CPHA}; latched at SS falling edge.
- `tx_data` in DATA_WIDTH: word to transmit.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: TX holding register empty.
- `rx_data` out DATA_WIDTH: last complete received word; held until next word.
- `rx_valid` out 1: one-cycle pulse, `rx_data` updated.
- `tx_underrun` out 1: one-cycle pulse, shifter loaded with no buffered word.
- `frame_err` out 1: one-cycle pulse, SS deasserted with a partial word.
- `busy` out 1: frame in progress (state ≠ IDLE).

## Operation
- Synchronise SCLK, MOSI, SS through `SYNC_STAGES` flops; edge detect compares synchronised SCLK with a one-cycle delayed copy, and likewise SS.
- Leading edge = rising if CPOL=0, falling if CPOL=1. Sample edge = leading if CPHA=0, trailing if CPHA=1; shift edge is the other.
- TX holding register: one entry. `tx_ready` = empty. `tx_valid && tx_ready` captures `tx_data`, sets full. Load into shifter empties it (same-cycle capture and load: load wins, capture takes the freed slot next cycle).
- States: IDLE, ACTIVE.
- IDLE → ACTIVE on synchronised SS falling edge: latch `mode`, `bit_cnt`=0, `word_done`=0, load TX shifter (buffer word, or all-zero plus `tx_underrun` pulse if empty).
- `MISO` = TX shifter MSB while ACTIVE.
- Sample edge: shift MOSI into RX shifter LSB; if `bit_cnt` = DATA_WIDTH−1, update `rx_data`, pulse `rx_valid`, `bit_cnt`←0, `word_done`←1; otherwise `bit_cnt`+1.
- Shift edge: if `bit_cnt`=0 and `word_done`, reload TX shifter (underrun rule applies), clear `word_done`; if `bit_cnt`≠0, shift TX left, zero fill; otherwise no change (CPHA=1 first edge, MSB already presented).
- ACTIVE → IDLE on synchronised SS rising edge: if `bit_cnt`≠0, pulse `frame_err`, discard partial word, no `rx_valid`. A pending reloaded TX word is lost; it is not returned to the buffer.
- Back-to-back words in one frame need no SS toggle.
- `mode` changes during ACTIVE are ignored.

## Timing
- Reset values: `MISO`=0, `MISO_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `tx_underrun`=0, `frame_err`=0, `busy`=0, synchronisers=1 for SS, 0 otherwise. Reset mid-frame aborts it silently, with no `frame_err`.
- Pin edge to detected edge: `SYNC_STAGES`+1 clocks. `rx_valid` is high the clock after the last sample edge is detected.
- `MISO` updates the clock after the detected shift edge or SS fall.
- SCLK high and low phases must each be ≥ `SYNC_STAGES`+2 clocks. The first SCLK edge must come ≥ `SYNC_STAGES`+2 clocks after SS falls.
- Simultaneous SS rise and sample edge: SS rise has priority; the edge is ignored.

## Test plan
- Mode 0, tx 0xA5 buffered, master sends 0x3C → `rx_data`=0x3C with one `rx_valid` pulse; master receives 0xA5; no underrun.
- Modes 1, 2, 3 each: tx 0x81, master sends 0x7E → `rx_data`=0x7E, master receives 0x81.
- Two-word frame, mode 0, tx 0x12 then 0x34 supplied when `tx_ready` rises; master sends 0xF0, 0x0F → two `rx_valid` pulses (0xF0, 0x0F); master receives 0x12, 0x34.
- Empty TX buffer at SS fall → `tx_underrun` pulse; MISO all zeros; RX still correct.
- SS released after 5 bits → `frame_err` pulse; `rx_data` unchanged; no `rx_valid`; next frame receives 0x55 correctly.
- Reset asserted mid-word, then a full frame with 0xC3 → all outputs at reset values; next frame `rx_data`=0xC3.
